// File: rtl/vcve2_csr_pkg.sv
//------------------------------------------------------------------------------
// Module : vcve2_csr_pkg
// Brief  : Shared op encodings and sequencer state type for CSR access logic.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vcve2_csr_pkg;

  localparam logic [1:0] c_OP_READ  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    CSR_READ  = c_OP_READ,
    CSR_WRITE = c_OP_WRITE,
    CSR_SET   = c_OP_SET,
    CSR_CLEAR = c_OP_CLEAR
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3
`ifdef VCVE2_CSR_ACCESS_READBACK_EN
    ,
    ST_CHECK = 3'd4
`endif
  } csr_acc_state_e;

endpackage

`default_nettype wire

// File: rtl/vcve2_csr_access_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : vcve2_csr_access_ctrl_if
// Brief  : Request/response and CSR-primitive signals of the access sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vcve2_csr_access_ctrl_if #(
  parameter int unsigned Width = 32
);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [Width-1:0] req_wdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [Width-1:0] rsp_rdata_o;
  logic             rsp_error_o;
  logic             csr_wr_en_o;
  logic [Width-1:0] csr_wr_data_o;
  logic [Width-1:0] csr_rd_data_i;
  logic             csr_rd_error_i;

  modport slave (
    input  req_valid_i, req_op_i, req_wdata_i, rsp_ready_i, csr_rd_data_i, csr_rd_error_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, csr_wr_en_o, csr_wr_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_wdata_i, rsp_ready_i, csr_rd_data_i, csr_rd_error_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o, csr_wr_en_o, csr_wr_data_o
  );

endinterface

`default_nettype wire

// File: rtl/vcve2_csr_modify.sv
//------------------------------------------------------------------------------
// Module : vcve2_csr_modify
// Brief  : Combinational read-modify-write value and write-needed decision.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vcve2_csr_modify
  import vcve2_csr_pkg::*;
#(
  parameter int unsigned     Width     = 32,
  parameter logic [Width-1:0] WriteMask = {Width{1'b1}}
) (
  input  csr_op_e          op_i,
  input  logic [Width-1:0] old_i,
  input  logic [Width-1:0] operand_i,
  output logic [Width-1:0] new_o,
  output logic             wr_needed_o
);

  logic [Width-1:0] w_mod;

  // SET/CLEAR with a zero operand cannot change anything, so no write is issued.
  always_comb begin
    w_mod       = old_i;
    wr_needed_o = 1'b1;
    case (op_i)
      CSR_READ:  wr_needed_o = 1'b0;
      CSR_WRITE: w_mod = operand_i;
      CSR_SET: begin
        w_mod       = old_i | operand_i;
        wr_needed_o = |operand_i;
      end
      CSR_CLEAR: begin
        w_mod       = old_i & ~operand_i;
        wr_needed_o = |operand_i;
      end
      default:   wr_needed_o = 1'b0;
    endcase
    new_o = (old_i & ~WriteMask) | (w_mod & WriteMask);
  end

endmodule

`default_nettype wire

// File: rtl/vcve2_csr_access_ctrl.sv
//------------------------------------------------------------------------------
// Module : vcve2_csr_access_ctrl
// Brief  : Valid/ready CSR request sequencer doing read-modify-write on one CSR.
//          Optional write read-back check: VCVE2_CSR_ACCESS_READBACK_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vcve2_csr_access_ctrl
  import vcve2_csr_pkg::*;
#(
  parameter int unsigned      Width     = 32,
  parameter logic [Width-1:0] WriteMask = {Width{1'b1}}
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  vcve2_csr_access_ctrl_if.slave  bus
);

  csr_acc_state_e   r_state;
  csr_acc_state_e   w_state_next;
  csr_op_e          r_op;
  logic [Width-1:0] r_wdata;
  logic [Width-1:0] r_old;
  logic [Width-1:0] r_new;
  logic             r_err;
  logic [Width-1:0] w_new;
  logic             w_wr_needed;
  logic             w_do_write;

  vcve2_csr_modify #(
    .Width     (Width),
    .WriteMask (WriteMask)
  ) u_modify (
    .op_i        (r_op),
    .old_i       (bus.csr_rd_data_i),
    .operand_i   (r_wdata),
    .new_o       (w_new),
    .wr_needed_o (w_wr_needed)
  );

  assign w_do_write = w_wr_needed & ~bus.csr_rd_error_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    bus.req_ready_o   = 1'b0;
    bus.rsp_valid_o   = 1'b0;
    bus.rsp_rdata_o   = '0;
    bus.rsp_error_o   = 1'b0;
    bus.csr_wr_en_o   = 1'b0;
    bus.csr_wr_data_o = r_new;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready_o = ~rst_i;
        if (bus.req_valid_i) w_state_next = ST_READ;
      end
      ST_READ: w_state_next = w_do_write ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        bus.csr_wr_en_o = 1'b1;
`ifdef VCVE2_CSR_ACCESS_READBACK_EN
        w_state_next    = ST_CHECK;
`else
        w_state_next    = ST_RESP;
`endif
      end
`ifdef VCVE2_CSR_ACCESS_READBACK_EN
      ST_CHECK: w_state_next = ST_RESP;
`endif
      ST_RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_rdata_o = r_old;
        bus.rsp_error_o = r_err;
        if (bus.rsp_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // r_new only moves when a write will follow, so the write-data port holds its last value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op    <= CSR_READ;
      r_wdata <= '0;
      r_old   <= '0;
      r_new   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid_i) begin
        r_op    <= csr_op_e'(bus.req_op_i);
        r_wdata <= bus.req_wdata_i;
      end
      if (r_state == ST_READ) begin
        r_old <= bus.csr_rd_data_i;
        r_err <= bus.csr_rd_error_i;
        if (w_do_write) r_new <= w_new;
      end
`ifdef VCVE2_CSR_ACCESS_READBACK_EN
      if (r_state == ST_CHECK && (bus.csr_rd_data_i != r_new || bus.csr_rd_error_i)) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  a_wr_en_known: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(bus.csr_wr_en_o));

endmodule

`default_nettype wire
